// File: rtl/w0rm_core_mem_arbiter.sv
// Shares one single-ported memory bus between the instruction fetch port and
// the load/store data port: round-robin on ties, with an optional ack timeout.
module w0rm_core_mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned INST_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic                  inst_valid,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, INST_WAIT, DATA_WAIT, RESP} state_t;
  typedef enum logic {GNT_INST, GNT_DATA} grant_t;

  state_t           state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic             hw_sel_q, hw_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hit_to, grant_data;

  logic                  mem_req_d, mem_we_d, inst_valid_d, data_valid_d;
  logic                  busy_d, timeout_err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, data_rdata_d;
  logic [INST_WIDTH-1:0] inst_data_d;

  // Byte-offset bits that word alignment discards.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[0], data_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_INST;
      hw_sel_q     <= 1'b0;
      cnt_q        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      inst_data    <= '0;
      inst_valid   <= 1'b0;
      data_rdata   <= '0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hw_sel_q     <= hw_sel_d;
      cnt_q        <= cnt_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      inst_data    <= inst_data_d;
      inst_valid   <= inst_valid_d;
      data_rdata   <= data_rdata_d;
      data_valid   <= data_valid_d;
      busy         <= busy_d;
      timeout_err  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    hw_sel_d      = hw_sel_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    inst_data_d   = inst_data;
    inst_valid_d  = 1'b0;
    data_rdata_d  = data_rdata;
    data_valid_d  = 1'b0;
    timeout_err_d = timeout_err;
    grant_data    = 1'b0;
    // Saturating count of WAIT cycles that have passed without an ack.
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    hit_to        = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_MAX);

    case (state_q)
      IDLE: begin
        grant_data = data_req && (!inst_req || (last_grant_q == GNT_INST));
        if (grant_data) begin
          state_d      = DATA_WAIT;
          last_grant_d = GNT_DATA;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = data_we;
          mem_addr_d   = {data_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata_d  = data_wdata;
        end else if (inst_req) begin
          state_d      = INST_WAIT;
          last_grant_d = GNT_INST;
          cnt_d        = '0;
          hw_sel_d     = inst_addr[1];
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = {inst_addr[ADDR_WIDTH-1:2], 2'b00};
        end
      end
      INST_WAIT, DATA_WAIT: begin
        // An ack in the cycle the limit is reached still completes normally.
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == INST_WAIT) begin
            inst_valid_d = 1'b1;
            inst_data_d  = hw_sel_q ? mem_rdata[2*INST_WIDTH-1:INST_WIDTH]
                                    : mem_rdata[INST_WIDTH-1:0];
          end else begin
            data_valid_d = 1'b1;
            data_rdata_d = mem_we ? '0 : mem_rdata;
          end
        end else if (hit_to) begin
          state_d       = RESP;
          mem_req_d     = 1'b0;
          cnt_d         = cnt_inc;
          timeout_err_d = 1'b1;
          if (state_q == INST_WAIT) begin
            inst_valid_d = 1'b1;
            inst_data_d  = '0;
          end else begin
            data_valid_d = 1'b1;
            data_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_w0rm_core_mem_arbiter.sv
// Directed bench for w0rm_core_mem_arbiter: reset, fetch, tie round-robin,
// store, ack-less timeout and ack-on-limit cases with hand-computed results.
module tb_w0rm_core_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic [IW-1:0] inst_data;
  logic          inst_valid;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  w0rm_core_mem_arbiter #(
    .DATA_WIDTH(DW), .INST_WIDTH(IW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_data(inst_data), .inst_valid(inst_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_valid(data_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
    data_addr = '0; data_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    cyc(); cyc();
    n_tests++;
    if ({mem_req, busy, inst_valid, data_valid, timeout_err, mem_we} !== 6'b0 || mem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got flags=%b addr=%h, want all 0", {mem_req, busy, inst_valid, data_valid, timeout_err, mem_we}, mem_addr);
    end
    reset = 1'b0;
    data_req = 1'b1; data_addr = 32'h2000_0010; data_we = 1'b0;
    wait_req(ok);
    n_tests++;
    if (!ok || mem_addr !== 32'h2000_0010 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_grant: ok=%0b addr=%h busy=%b, want 1 20000010 1", ok, mem_addr, busy);
    end
    cyc();
    #3 reset = 1'b1;
    #1;
    n_tests++;
    if ({mem_req, busy, data_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got req/busy/valid=%b want 000", {mem_req, busy, data_valid});
    end
    data_req = 1'b0;
    cyc();
    reset = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0040;
    data_req = 1'b1; data_addr = 32'h0000_0080;
    wait_req(ok);
    n_tests++;
    if (!ok || mem_addr !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL reset_first_tie: ok=%0b addr=%h want data addr 00000080", ok, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    cyc();
    mem_ack = 1'b0;
    n_tests++;
    if (data_valid !== 1'b1 || inst_valid !== 1'b0 || data_rdata !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL reset_tie_resp: dv=%b iv=%b rdata=%h want 1 0 00000077", data_valid, inst_valid, data_rdata);
    end
    inst_req = 1'b0; data_req = 1'b0;
    cyc();
  endtask

  task automatic test_fetch();
    int edges;
    inst_req = 1'b1; inst_addr = 32'h2000_0002;
    edges = 0;
    cyc(); edges++;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h2000_0000 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_mem: req=%b addr=%h we=%b want 1 20000000 0", mem_req, mem_addr, mem_we);
    end
    cyc(); edges++;
    mem_ack = 1'b1; mem_rdata = 32'hABCD_1234;
    cyc(); edges++;
    mem_ack = 1'b0;
    n_tests++;
    if (inst_valid !== 1'b1 || inst_data !== 16'hABCD || data_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_resp: iv=%b data=%h dv=%b req=%b want 1 abcd 0 0", inst_valid, inst_data, data_valid, mem_req);
    end
    n_tests++;
    if (edges + 1 != 4) begin
      n_fail++;
      $display("FAIL fetch_latency: got %0d want 4", edges + 1);
    end
    inst_req = 1'b0;
    cyc();
    n_tests++;
    if (inst_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse: iv=%b busy=%b want 0 0", inst_valid, busy);
    end
  endtask

  task automatic test_tie();
    bit ok;
    bit exp_data;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] rd;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    data_req = 1'b1; data_addr = 32'h0000_0200; data_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_data = (i % 2 == 0);
      exp_addr = exp_data ? 32'h0000_0200 : 32'h0000_0100;
      rd = 32'hC0DE_0000 + 32'(i);
      wait_req(ok);
      n_tests++;
      if (!ok || mem_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL tie_grant%0d: ok=%0b addr=%h want %h", i, ok, mem_addr, exp_addr);
      end
      mem_ack = 1'b1; mem_rdata = rd;
      cyc();
      mem_ack = 1'b0;
      n_tests++;
      if (data_valid !== exp_data || inst_valid !== !exp_data ||
          (exp_data && data_rdata !== rd) || (!exp_data && inst_data !== rd[15:0])) begin
        n_fail++;
        $display("FAIL tie_resp%0d: dv=%b iv=%b rdata=%h idata=%h rd=%h", i, data_valid, inst_valid, data_rdata, inst_data, rd);
      end
      cyc();
    end
    inst_req = 1'b0; data_req = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000_0000;
    wait_req(ok);
    n = 0;
    while (mem_req === 1'b1 && n < 10) begin
      n++;
      cyc();
    end
    n_tests++;
    if (!ok || n != 4) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: ok=%0b got %0d want 4", ok, n);
    end
    n_tests++;
    if (data_valid !== 1'b1 || data_rdata !== 32'h0 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_resp: dv=%b rdata=%h err=%b want 1 00000000 1", data_valid, data_rdata, timeout_err);
    end
    data_req = 1'b0;
    cyc(); cyc(); cyc();
    n_tests++;
    if (data_valid !== 1'b0 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_sticky: dv=%b err=%b busy=%b want 0 1 0", data_valid, timeout_err, busy);
    end
  endtask

  task automatic test_ack_at_limit();
    bit ok;
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_err_cleared: got %b want 0", timeout_err);
    end
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h3000_0004;
    wait_req(ok);
    cyc(); cyc(); cyc();
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    cyc();
    mem_ack = 1'b0;
    n_tests++;
    if (!ok || data_valid !== 1'b1 || data_rdata !== 32'h5555_AAAA || timeout_err !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_ack_wins: ok=%0b dv=%b rdata=%h err=%b req=%b want 1 1 5555aaaa 0 0", ok, data_valid, data_rdata, timeout_err, mem_req);
    end
    data_req = 1'b0;
    cyc();
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_err_after: got %b want 0", timeout_err);
    end
  endtask

  task automatic test_store();
    bit ok;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h1000_0007; data_wdata = 32'hDEAD_BEEF;
    wait_req(ok);
    n_tests++;
    if (!ok || mem_addr !== 32'h1000_0004 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL store_mem: ok=%0b addr=%h we=%b wdata=%h want 1 10000004 1 deadbeef", ok, mem_addr, mem_we, mem_wdata);
    end
    data_wdata = 32'h0;
    cyc(); cyc();
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h1000_0004) begin
      n_fail++;
      $display("FAIL store_hold: req=%b we=%b wdata=%h addr=%h", mem_req, mem_we, mem_wdata, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    mem_ack = 1'b0;
    n_tests++;
    if (data_valid !== 1'b1 || data_rdata !== 32'h0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL store_resp: dv=%b rdata=%h req=%b want 1 00000000 0", data_valid, data_rdata, mem_req);
    end
    data_req = 1'b0;
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || inst_valid !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: busy=%b dv=%b iv=%b req=%b want 0 0 0 0", busy, data_valid, inst_valid, mem_req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fetch();
    test_tie();
    test_timeout();
    test_ack_at_limit();
    test_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/w0rm_core_mem_arbiter.md
Name: w0rm_core_mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction fetch port and its load/store data port.
- Sits between the IFetch stage and the memory subsystem, and between the memory/writeback stage and the same memory.
- Sequences each access through request → memory handshake → response.
- Arbitrates round-robin on ties and aborts hung accesses with a timeout.

Parameters:
- DATA_WIDTH, 32, memory data word width and data-port width.
- INST_WIDTH, 16, instruction width; one halfword of a memory word.
- ADDR_WIDTH, 32, address width of all ports.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- inst_req  input  1  fetch request; held until inst_valid
- inst_addr  input  ADDR_WIDTH  fetch byte address; halfword aligned
- inst_data  output  INST_WIDTH  fetched instruction
- inst_valid  output  1  one-cycle fetch completion pulse
- data_req  input  1  load/store request; held until data_valid
- data_we  input  1  1 = store, 0 = load
- data_addr  input  ADDR_WIDTH  load/store word address
- data_wdata  input  DATA_WIDTH  store data
- data_rdata  output  DATA_WIDTH  load data
- data_valid  output  1  one-cycle load/store completion pulse
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory address
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data; valid when mem_ack = 1
- mem_ack  input  1  memory completion; one cycle
- busy  output  1  1 whenever state is not IDLE
- timeout_err  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset: asynchronous, active-high. All outputs go to 0. State goes to IDLE, last_grant goes to INST, and the timeout counter clears. Any in-flight transaction is discarded; mem_req drops immediately, not at the next edge.
- All outputs are registered.
- States: IDLE, INST_WAIT, DATA_WAIT, RESP.
- IDLE: samples inst_req and data_req at the clock edge.
  - Only one request asserted: grant it.
  - Both asserted: grant the port opposite to last_grant. The first tie after reset therefore goes to DATA.
  - On a grant: update last_grant, latch the granted address (plus we/wdata for DATA) into mem_*, set mem_req = 1, and enter INST_WAIT or DATA_WAIT.
  - For an INST grant, mem_addr = inst_addr with bits [1:0] forced to 0, mem_we = 0, and inst_addr[1] is kept as the halfword select.
  - For a DATA grant, data_addr bits [1:0] are forced to 0.
- x_WAIT: mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On mem_ack = 1: mem_req drops at that edge and state goes to RESP.
  - In the RESP cycle, exactly one of inst_valid or data_valid = 1.
  - inst_data = mem_rdata[15:0] when the halfword select = 0, else mem_rdata[31:16].
  - data_rdata = mem_rdata on a load, 0 on a store.
- RESP: lasts one cycle, then IDLE. Requests are not sampled during RESP. The requester must deassert its req no later than the cycle after its valid pulse.
- Latency: req first sampled at edge N → mem_req high from cycle N+1. mem_ack sampled at edge M → valid high in cycle M+1. The earliest next grant is sampled at edge M+2, with mem_req high in M+3. Minimum request-to-valid is 3 cycles.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter clears on grant and increments every WAIT cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, the pending port gets its valid pulse in RESP with zero data, and timeout_err sets.
  - If mem_ack arrives in the same cycle the count is reached, the ack wins: normal completion, no error.
- mem_ack while in IDLE or RESP is ignored.
- A request dropped mid-WAIT is not supported. The transaction still completes and the valid pulse is still issued.
- Width rule: the timeout counter is clog2(TIMEOUT_CYCLES+1) bits and saturates at TIMEOUT_CYCLES; there is no wrap.

Test Plan:
- Reset mid-DATA_WAIT with mem_addr = 0x2000_0010 → mem_req, busy and data_valid are 0 before the next clk edge. After release, the first tie grants DATA.
- Single fetch: inst_addr = 0x2000_0002, memory acks 2 cycles after mem_req with mem_rdata = 0xABCD_1234 → mem_addr = 0x2000_0000, inst_data = 0xABCD, inst_valid is a single 1-cycle pulse, total latency 4 cycles.
- Simultaneous inst_req and data_req held for 4 transactions, ack latency 1 → grant order DATA, INST, DATA, INST, with no back-to-back grant to the same port.
- Store: data_addr = 0x1000_0007, data_wdata = 0xDEAD_BEEF, data_we = 1 → mem_addr = 0x1000_0004, mem_we = 1, mem_wdata held until ack, data_rdata = 0, data_valid pulses.
- TIMEOUT_CYCLES = 4, mem_ack never asserted on a load → mem_req drops after 4 WAIT cycles, data_valid pulses with data_rdata = 0, and timeout_err stays 1 until reset.
- mem_ack in the exact cycle the timeout is reached with mem_rdata = 0x5555_AAAA → normal completion, data_rdata = 0x5555_AAAA, timeout_err remains 0.
